// File: rtl/ebox_mbox_req_if.sv
// EBOX <-> MCL/MBOX request bundle for ebox_mbox_req.
// master = sequencer side, slave = MCL/MBOX environment side.
interface ebox_mbox_req_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 36
);
    logic              CYC_REQ;
    logic              VMA_READ;
    logic              VMA_WRITE;
    logic              VMA_PAUSE;
    logic              VMA_FETCH;
    logic              LOAD_AR;
    logic              LOAD_ARX;
    logic [ADDR_W-1:0] VMA;
    logic [DATA_W-1:0] STORE_DATA;

    logic              MBOX_REQ;
    logic              MBOX_RD;
    logic              MBOX_WR;
    logic              MBOX_FETCH;
    logic [ADDR_W-1:0] MBOX_ADDR;
    logic [DATA_W-1:0] MBOX_WDATA;
    logic              MBOX_ACK;
    logic              MBOX_RESP;
    logic              MBOX_ERR;
    logic [DATA_W-1:0] MBOX_RDATA;

    logic              MB_WAIT;
    logic              AR_LOAD;
    logic              ARX_LOAD;
    logic [DATA_W-1:0] MB_DATA;
    logic              MEM_FAIL;
    logic              RPW_ABORT;

    modport master (
        input  CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE, VMA_FETCH,
        input  LOAD_AR, LOAD_ARX, VMA, STORE_DATA,
        input  MBOX_ACK, MBOX_RESP, MBOX_ERR, MBOX_RDATA,
        output MBOX_REQ, MBOX_RD, MBOX_WR, MBOX_FETCH,
        output MBOX_ADDR, MBOX_WDATA,
        output MB_WAIT, AR_LOAD, ARX_LOAD, MB_DATA,
        output MEM_FAIL, RPW_ABORT
    );

    modport slave (
        output CYC_REQ, VMA_READ, VMA_WRITE, VMA_PAUSE, VMA_FETCH,
        output LOAD_AR, LOAD_ARX, VMA, STORE_DATA,
        output MBOX_ACK, MBOX_RESP, MBOX_ERR, MBOX_RDATA,
        input  MBOX_REQ, MBOX_RD, MBOX_WR, MBOX_FETCH,
        input  MBOX_ADDR, MBOX_WDATA,
        input  MB_WAIT, AR_LOAD, ARX_LOAD, MB_DATA,
        input  MEM_FAIL, RPW_ABORT
    );
endinterface

// File: rtl/ebox_mbox_req.sv
// EBOX-side MBOX request sequencer (read, write, read-pause-write).
// Optional watchdog: define MBOX_REQ_TIMEOUT_EN.
module ebox_mbox_req #(
    parameter int ADDR_W         = 23,
    parameter int DATA_W         = 36,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic            clk,
    input  logic            MR_RESET_n,
    ebox_mbox_req_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RDWAIT,
        PAUSE,
        WRWAIT
    } state_e;

    state_e            state_q;
    logic              req_q;
    logic              rd_q;
    logic              wr_q;
    logic              fetch_q;
    logic              pause_q;
    logic              ld_ar_q;
    logic              ld_arx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mb_data_q;
    logic              ar_load_q;
    logic              arx_load_q;
    logic              mem_fail_q;
    logic              rpw_abort_q;

    logic new_req;
    logic waiting;
    logic done;
    logic tmo_hit;

    assign new_req = bus.CYC_REQ & (bus.VMA_READ | bus.VMA_WRITE);
    assign waiting = (state_q == REQ) | (state_q == RDWAIT)
                   | (state_q == WRWAIT);

    // A response only counts once the request has been acknowledged.
    always_comb begin
        done = 1'b0;
        unique case (state_q)
            REQ:     done = bus.MBOX_ACK & bus.MBOX_RESP;
            RDWAIT:  done = bus.MBOX_RESP;
            WRWAIT:  done = bus.MBOX_RESP;
            default: done = 1'b0;
        endcase
    end

`ifdef MBOX_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_q;

    assign tmo_hit = waiting
                   & (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside the wait states, so REQ entry starts at 0.
    always_ff @(posedge clk or negedge MR_RESET_n) begin
        if (!MR_RESET_n) begin
            tmo_q <= '0;
        end else if (waiting) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge MR_RESET_n) begin
        if (!MR_RESET_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            fetch_q     <= 1'b0;
            pause_q     <= 1'b0;
            ld_ar_q     <= 1'b0;
            ld_arx_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mb_data_q   <= '0;
            ar_load_q   <= 1'b0;
            arx_load_q  <= 1'b0;
            mem_fail_q  <= 1'b0;
            rpw_abort_q <= 1'b0;
        end else begin
            ar_load_q   <= 1'b0;
            arx_load_q  <= 1'b0;
            mem_fail_q  <= 1'b0;
            rpw_abort_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (new_req) begin
                        state_q  <= REQ;
                        req_q    <= 1'b1;
                        rd_q     <= bus.VMA_READ;
                        wr_q     <= bus.VMA_WRITE;
                        fetch_q  <= bus.VMA_FETCH;
                        pause_q  <= bus.VMA_PAUSE;
                        ld_ar_q  <= bus.LOAD_AR;
                        ld_arx_q <= bus.LOAD_ARX;
                        addr_q   <= bus.VMA;
                        if (bus.VMA_WRITE & ~bus.VMA_PAUSE) begin
                            wdata_q <= bus.STORE_DATA;
                        end
                    end
                end
                REQ: begin
                    if (bus.MBOX_ACK) begin
                        req_q   <= 1'b0;
                        state_q <= rd_q ? RDWAIT : WRWAIT;
                    end else if (tmo_hit) begin
                        req_q      <= 1'b0;
                        mem_fail_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                RDWAIT, WRWAIT: begin
                    if (tmo_hit & ~bus.MBOX_RESP) begin
                        mem_fail_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                PAUSE: begin
                    if (bus.CYC_REQ & bus.VMA_WRITE) begin
                        // Write half of RPW reuses the held address.
                        state_q  <= REQ;
                        req_q    <= 1'b1;
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b1;
                        fetch_q  <= 1'b0;
                        pause_q  <= 1'b0;
                        ld_ar_q  <= 1'b0;
                        ld_arx_q <= 1'b0;
                        wdata_q  <= bus.STORE_DATA;
                    end else if (bus.CYC_REQ) begin
                        rpw_abort_q <= 1'b1;
                        state_q     <= IDLE;
                        if (new_req) begin
                            state_q  <= REQ;
                            req_q    <= 1'b1;
                            rd_q     <= bus.VMA_READ;
                            wr_q     <= 1'b0;
                            fetch_q  <= bus.VMA_FETCH;
                            pause_q  <= bus.VMA_PAUSE;
                            ld_ar_q  <= bus.LOAD_AR;
                            ld_arx_q <= bus.LOAD_ARX;
                            addr_q   <= bus.VMA;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase

            // Completion overrides the wait-state transitions above.
            if (done) begin
                req_q <= 1'b0;
                if (bus.MBOX_ERR) begin
                    mem_fail_q <= 1'b1;
                    state_q    <= IDLE;
                end else if (rd_q) begin
                    mb_data_q  <= bus.MBOX_RDATA;
                    ar_load_q  <= ld_ar_q;
                    arx_load_q <= ld_arx_q;
                    state_q    <= pause_q ? PAUSE : IDLE;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.MBOX_REQ   = req_q;
    assign bus.MBOX_RD    = rd_q;
    assign bus.MBOX_WR    = wr_q;
    assign bus.MBOX_FETCH = fetch_q;
    assign bus.MBOX_ADDR  = addr_q;
    assign bus.MBOX_WDATA = wdata_q;
    assign bus.MB_WAIT    = waiting;
    assign bus.AR_LOAD    = ar_load_q;
    assign bus.ARX_LOAD   = arx_load_q;
    assign bus.MB_DATA    = mb_data_q;
    assign bus.MEM_FAIL   = mem_fail_q;
    assign bus.RPW_ABORT  = rpw_abort_q;

endmodule

// File: tb/tb_ebox_mbox_req.sv
// Directed bench for ebox_mbox_req: read, write, RPW, errors,
// async reset and the no-ACK / watchdog case.
`timescale 1ns/1ps
module tb_ebox_mbox_req;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   held;

    ebox_mbox_req_if bus ();

    ebox_mbox_req #(
        .ADDR_W(23),
        .DATA_W(36),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .MR_RESET_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic rd, input logic wr, input logic pa,
                       input logic ar, input logic arx,
                       input logic [22:0] vma, input logic [35:0] sd);
        bus.CYC_REQ    = 1'b1;
        bus.VMA_READ   = rd;
        bus.VMA_WRITE  = wr;
        bus.VMA_PAUSE  = pa;
        bus.LOAD_AR    = ar;
        bus.LOAD_ARX   = arx;
        bus.VMA        = vma;
        bus.STORE_DATA = sd;
        step();
        bus.CYC_REQ    = 1'b0;
        bus.VMA_READ   = 1'b0;
        bus.VMA_WRITE  = 1'b0;
        bus.VMA_PAUSE  = 1'b0;
        bus.LOAD_AR    = 1'b0;
        bus.LOAD_ARX   = 1'b0;
    endtask

    task automatic resp(input logic ack, input logic err,
                        input logic [35:0] d);
        bus.MBOX_ACK   = ack;
        bus.MBOX_RESP  = 1'b1;
        bus.MBOX_ERR   = err;
        bus.MBOX_RDATA = d;
        step();
        bus.MBOX_ACK   = 1'b0;
        bus.MBOX_RESP  = 1'b0;
        bus.MBOX_ERR   = 1'b0;
    endtask

    task automatic ack();
        bus.MBOX_ACK = 1'b1;
        step();
        bus.MBOX_ACK = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.CYC_REQ    = 1'b0;
        bus.VMA_READ   = 1'b0;
        bus.VMA_WRITE  = 1'b0;
        bus.VMA_PAUSE  = 1'b0;
        bus.VMA_FETCH  = 1'b0;
        bus.LOAD_AR    = 1'b0;
        bus.LOAD_ARX   = 1'b0;
        bus.VMA        = '0;
        bus.STORE_DATA = '0;
        bus.MBOX_ACK   = 1'b0;
        bus.MBOX_RESP  = 1'b0;
        bus.MBOX_ERR   = 1'b0;
        bus.MBOX_RDATA = '0;
        step();
        step();
        chk("rst_req", bus.MBOX_REQ, 0);
        chk("rst_wait", bus.MB_WAIT, 0);
        chk("rst_data", bus.MB_DATA, 0);
        chk("rst_strobes", {bus.AR_LOAD, bus.ARX_LOAD,
                            bus.MEM_FAIL, bus.RPW_ABORT}, 0);
        #2 rst_n = 1'b1;
        step();

        // simple read, ACK after two cycles
        cyc(1, 0, 0, 1, 0, 23'o1234, 36'o0);
        chk("rd_req", bus.MBOX_REQ, 1);
        chk("rd_rd", bus.MBOX_RD, 1);
        chk("rd_addr", bus.MBOX_ADDR, 23'o1234);
        chk("rd_wait0", bus.MB_WAIT, 1);
        step();
        chk("rd_req_hold", bus.MBOX_REQ, 1);
        ack();
        chk("rd_req_drop", bus.MBOX_REQ, 0);
        chk("rd_wait2", bus.MB_WAIT, 1);
        resp(0, 0, 36'o777777000001);
        chk("rd_ar_load", bus.AR_LOAD, 1);
        chk("rd_arx_load", bus.ARX_LOAD, 0);
        chk("rd_data", bus.MB_DATA, 36'o777777000001);
        chk("rd_idle", bus.MB_WAIT, 0);
        step();
        chk("rd_ar_once", bus.AR_LOAD, 0);

        // write
        cyc(0, 1, 0, 0, 0, 23'o4000, 36'o123456654321);
        chk("wr_wr", {bus.MBOX_WR, bus.MBOX_RD}, 2'b10);
        chk("wr_wdata", bus.MBOX_WDATA, 36'o123456654321);
        step();
        chk("wr_wdata_hold", bus.MBOX_WDATA, 36'o123456654321);
        ack();
        chk("wr_wrwait", bus.MB_WAIT, 1);
        chk("wr_wdata_ack", bus.MBOX_WDATA, 36'o123456654321);
        resp(0, 0, 36'o0);
        chk("wr_idle", bus.MB_WAIT, 0);
        chk("wr_no_ar", bus.AR_LOAD, 0);
        chk("wr_data_kept", bus.MB_DATA, 36'o777777000001);

        // RPW, read half completes with ACK+RESP together
        cyc(1, 0, 1, 1, 0, 23'o2222, 36'o0);
        resp(1, 0, 36'o5);
        chk("rpw_ar_load", bus.AR_LOAD, 1);
        chk("rpw_data", bus.MB_DATA, 36'o5);
        chk("rpw_pause_wait", bus.MB_WAIT, 0);
        chk("rpw_pause_req", bus.MBOX_REQ, 0);
        for (int i = 0; i < 4; i++) step();
        chk("rpw_pause_hold", bus.MB_WAIT, 0);
        cyc(0, 1, 0, 0, 0, 23'o7777, 36'o6);
        chk("rpw_wr_req", bus.MBOX_REQ, 1);
        chk("rpw_addr", bus.MBOX_ADDR, 23'o2222);
        chk("rpw_wdata", bus.MBOX_WDATA, 36'o6);
        chk("rpw_wr", {bus.MBOX_WR, bus.MBOX_RD}, 2'b10);
        chk("rpw_no_abort", bus.RPW_ABORT, 0);
        ack();
        resp(0, 0, 36'o0);
        chk("rpw_done", bus.MB_WAIT, 0);

        // read error
        cyc(1, 0, 0, 1, 0, 23'o10, 36'o0);
        ack();
        resp(0, 1, 36'o111);
        chk("err_fail", bus.MEM_FAIL, 1);
        chk("err_no_ar", bus.AR_LOAD, 0);
        chk("err_data", bus.MB_DATA, 36'o5);
        chk("err_idle", bus.MB_WAIT, 0);
        step();
        chk("err_fail_once", bus.MEM_FAIL, 0);

        // RPW read error must not enter PAUSE
        cyc(1, 0, 1, 1, 0, 23'o14, 36'o0);
        ack();
        resp(0, 1, 36'o222);
        chk("rpwerr_fail", bus.MEM_FAIL, 1);
        chk("rpwerr_data", bus.MB_DATA, 36'o5);
        cyc(1, 0, 0, 0, 1, 23'o20, 36'o0);
        chk("rpwerr_no_abort", bus.RPW_ABORT, 0);
        chk("rpwerr_addr", bus.MBOX_ADDR, 23'o20);
        resp(1, 0, 36'o42);
        chk("arx_load", {bus.AR_LOAD, bus.ARX_LOAD}, 2'b01);
        chk("arx_data", bus.MB_DATA, 36'o42);

        // PAUSE abandoned by a plain read
        cyc(1, 0, 1, 1, 0, 23'o3333, 36'o0);
        resp(1, 0, 36'o7);
        chk("abort_pause", bus.MB_WAIT, 0);
        cyc(1, 0, 0, 1, 0, 23'o30, 36'o0);
        chk("abort_pulse", bus.RPW_ABORT, 1);
        chk("abort_req", bus.MBOX_REQ, 1);
        chk("abort_addr", bus.MBOX_ADDR, 23'o30);
        resp(1, 0, 36'o55);
        chk("abort_once", bus.RPW_ABORT, 0);
        chk("abort_data", bus.MB_DATA, 36'o55);

        // async reset while MBOX_REQ is up
        cyc(1, 0, 0, 1, 0, 23'o40, 36'o0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", bus.MBOX_REQ, 0);
        chk("arst_wait_req", bus.MB_WAIT, 0);
        #2 rst_n = 1'b1;
        step();

        // async reset mid-RDWAIT, then stray RESP
        cyc(1, 0, 0, 1, 0, 23'o44, 36'o0);
        ack();
        chk("arst_rdwait", bus.MB_WAIT, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wait", bus.MB_WAIT, 0);
        chk("arst_data", bus.MB_DATA, 0);
        #2 rst_n = 1'b1;
        resp(0, 0, 36'o77);
        chk("stray_no_ar", bus.AR_LOAD, 0);
        chk("stray_data", bus.MB_DATA, 0);
        chk("stray_wait", bus.MB_WAIT, 0);

        // no ACK at all
        cyc(1, 0, 0, 1, 0, 23'o50, 36'o0);
        held = bus.MBOX_REQ ? 1 : 0;
`ifdef MBOX_REQ_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            if (bus.MBOX_REQ) held++;
        end
        chk("tmo_held", held, 8);
        step();
        chk("tmo_req", bus.MBOX_REQ, 0);
        chk("tmo_fail", bus.MEM_FAIL, 1);
        chk("tmo_idle", bus.MB_WAIT, 0);
        resp(0, 0, 36'o66);
        chk("tmo_stray_ar", bus.AR_LOAD, 0);
        chk("tmo_stray_data", bus.MB_DATA, 0);
`else
        for (int i = 1; i < 100; i++) begin
            step();
            if (bus.MBOX_REQ) held++;
        end
        chk("noack_held", held, 100);
        chk("noack_fail", bus.MEM_FAIL, 0);
        resp(1, 0, 36'o66);
        chk("noack_done", bus.MB_DATA, 36'o66);
        chk("noack_idle", bus.MB_WAIT, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ebox_mbox_req.md
Name: ebox_mbox_req

Overview:
EBOX-side memory request sequencer sitting directly downstream of MCL.
- Consumes MCL's cycle request and its VMA qualifiers: read, write, pause, fetch, load-AR/ARX.
- Runs the EBOX↔MBOX request/acknowledge/response handshake, including read-pause-write (RPW).
- Drives the MB-wait stall back to the EBOX and the AR/ARX load strobes with returned memory data.

Parameters:
ADDR_W, 23, physical/virtual address width (VMA bits 13:35)
DATA_W, 36, memory word width
TIMEOUT_CYCLES, 1023, watchdog limit in clk cycles (used only with MBOX_REQ_TIMEOUT_EN)

Ports:
clk  in  1  EBOX clock (CLK.MCL domain)
MR_RESET_n  in  1  asynchronous, active-low reset
CYC_REQ  in  1  MCL.MBOX_CYC_REQ
VMA_READ  in  1  cycle reads memory
VMA_WRITE  in  1  cycle writes memory
VMA_PAUSE  in  1  read half of RPW; write follows later
VMA_FETCH  in  1  instruction fetch
LOAD_AR  in  1  return data goes to AR
LOAD_ARX  in  1  return data goes to ARX
VMA  in  ADDR_W  request address
STORE_DATA  in  DATA_W  AR value for writes
MBOX_REQ  out  1  request to MBOX
MBOX_RD  out  1  request is a read
MBOX_WR  out  1  request is a write
MBOX_FETCH  out  1  request is a fetch
MBOX_ADDR  out  ADDR_W  held address
MBOX_WDATA  out  DATA_W  held write data
MBOX_ACK  in  1  MBOX accepted request
MBOX_RESP  in  1  read data valid / write complete
MBOX_ERR  in  1  qualifies MBOX_RESP as page fail / NXM
MBOX_RDATA  in  DATA_W  read data
MB_WAIT  out  1  stall EBOX
AR_LOAD  out  1  one-cycle strobe: load AR from MB_DATA
ARX_LOAD  out  1  one-cycle strobe: load ARX from MB_DATA
MB_DATA  out  DATA_W  captured read data
MEM_FAIL  out  1  one-cycle strobe: cycle ended in error
RPW_ABORT  out  1  one-cycle strobe: pending RPW write abandoned

Behaviour:
- Reset, asynchronous on MR_RESET_n low:
  - State IDLE.
  - All outputs 0, including MB_DATA.
  - MBOX_REQ drops immediately, including mid-cycle; no response is awaited after reset.
- States: IDLE, REQ, RDWAIT, PAUSE, WRWAIT.
- MB_WAIT = (state is REQ, RDWAIT or WRWAIT). It is combinational from state and is 0 in IDLE and PAUSE.
- IDLE:
  - On CYC_REQ, latch VMA and qualifiers.
  - Latch STORE_DATA when VMA_WRITE & ~VMA_PAUSE.
  - Go to REQ next cycle.
  - CYC_REQ with neither READ nor WRITE is ignored.
- REQ:
  - MBOX_REQ=1; MBOX_RD/WR/FETCH/ADDR/WDATA stable from latched values.
  - Hold until MBOX_ACK.
  - On ACK: reads go to RDWAIT; writes go to WRWAIT.
  - ACK and RESP in the same cycle complete the cycle directly, with the RDWAIT/WRWAIT completion actions taken in that cycle.
- RDWAIT, on RESP & ~ERR:
  - MB_DATA <= MBOX_RDATA.
  - Next cycle: AR_LOAD = latched LOAD_AR and ARX_LOAD = latched LOAD_ARX, each for exactly one cycle.
  - Next state: PAUSE if latched VMA_PAUSE, else IDLE.
- PAUSE (RPW hold):
  - MBOX_REQ=0, address retained.
  - CYC_REQ & VMA_WRITE: latch STORE_DATA only (VMA ignored, held address reused), force write, go to REQ.
  - CYC_REQ without VMA_WRITE: pulse RPW_ABORT and treat it as a fresh IDLE request in the same cycle.
- WRWAIT: on RESP go to IDLE.
- Error: any RESP & ERR (RDWAIT or WRWAIT) pulses MEM_FAIL for one cycle, suppresses AR/ARX_LOAD, leaves MB_DATA unchanged, and goes to IDLE. This includes the read half of an RPW, so PAUSE is skipped.
- CYC_REQ while MB_WAIT=1 is ignored; MCL must not issue it.
- RESP without an outstanding ACKed request is ignored.
- Back-to-back: a new CYC_REQ is accepted in the cycle the FSM enters IDLE.

Optional Feature:
MBOX_REQ_TIMEOUT_EN
- Enabled:
  - A counter clears on entry to REQ and increments in REQ/RDWAIT/WRWAIT.
  - When it reaches TIMEOUT_CYCLES: drop MBOX_REQ, pulse MEM_FAIL, go to IDLE.
  - A later stray RESP is ignored.
- Disabled: no counter; the FSM waits indefinitely for ACK/RESP.

Test Plan:
- Simple read: CYC_REQ READ LOAD_AR VMA=0o1234; ACK after 2 cycles; RESP with RDATA=0o777777000001 → MB_WAIT high 3+ cycles, one AR_LOAD pulse, MB_DATA=0o777777000001, state IDLE.
- Write: CYC_REQ WRITE STORE_DATA=0o123456654321 → MBOX_WR=1 and MBOX_WDATA held through ACK; RESP → IDLE with no AR_LOAD.
- RPW:
  - Read with PAUSE, RESP data 5 → AR_LOAD, MB_WAIT=0 in PAUSE.
  - After 4 cycles, CYC_REQ WRITE STORE_DATA=6 with a different VMA → MBOX_ADDR is the original address, WDATA=6.
- Error: read gets RESP+ERR → MEM_FAIL for one cycle, no AR_LOAD, MB_DATA unchanged. RPW read with ERR → no PAUSE entry.
- Reset mid-RDWAIT: deassert MR_RESET_n asynchronously → MBOX_REQ/MB_WAIT 0 immediately; a later RESP is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=8): no ACK → MBOX_REQ drops after 8 cycles, MEM_FAIL pulse, IDLE. With the macro off, MBOX_REQ stays asserted for 100 cycles.
